// File: rtl/square_period_gen.sv
// Square-wave generator: a 32-step restoring divider turns a frequency request into a half-period.
// New half-periods are applied only at output edges, so retuning never produces runt pulses.
module square_period_gen #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] freq,
    output logic        square,
    output logic        busy,
    output logic        running,
    output logic [31:0] half_period
);

    localparam logic [31:0] DIVIDEND = 32'(CLK_HZ);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t      state;
    logic [31:0] freq_q;
    logic [31:0] quot;
    logic [32:0] rem;
    logic [32:0] dvsr;
    logic [4:0]  step;
    logic [31:0] pend_hp;
    logic        pend_vld;
    logic [31:0] cnt;

    logic [33:0] trial;
    logic        trial_ge;
    logic [32:0] rem_sub;
    logic [31:0] result;

    // rem < dvsr always holds, so the 33-bit difference never loses a bit.
    always_comb begin
        trial    = {rem, quot[31]};
        trial_ge = (trial >= {1'b0, dvsr});
        rem_sub  = trial[32:0] - dvsr;
        result   = quot;
        if (quot == 32'd0 && freq_q != 32'd0)
            result = 32'd1;
    end

    assign running = (half_period != 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            freq_q      <= '0;
            quot        <= '0;
            rem         <= '0;
            dvsr        <= '0;
            step        <= '0;
            pend_hp     <= '0;
            pend_vld    <= 1'b0;
            cnt         <= '0;
            half_period <= '0;
            square      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (half_period == 32'd0) begin
                if (pend_vld) begin
                    pend_vld <= 1'b0;
                    square   <= 1'b0;
                    if (pend_hp != 32'd0) begin
                        half_period <= pend_hp;
                        cnt         <= pend_hp - 32'd1;
                    end
                end
            end else if (cnt == 32'd0) begin
                if (pend_vld) begin
                    pend_vld <= 1'b0;
                    if (pend_hp == 32'd0) begin
                        square      <= 1'b0;
                        half_period <= '0;
                        cnt         <= '0;
                    end else begin
                        square      <= ~square;
                        half_period <= pend_hp;
                        cnt         <= pend_hp - 32'd1;
                    end
                end else begin
                    square <= ~square;
                    cnt    <= half_period - 32'd1;
                end
            end else begin
                cnt <= cnt - 32'd1;
            end

            // Placed after the counter so a fresh result beats a same-cycle consume.
            case (state)
                IDLE: begin
                    if (freq != freq_q) begin
                        freq_q <= freq;
                        busy   <= 1'b1;
                        rem    <= '0;
                        dvsr   <= {freq, 1'b0};
                        step   <= '0;
                        if (freq == 32'd0) begin
                            quot  <= '0;
                            state <= DONE;
                        end else begin
                            quot  <= DIVIDEND;
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem  <= trial_ge ? rem_sub : trial[32:0];
                    quot <= {quot[30:0], trial_ge};
                    step <= step + 5'd1;
                    if (step == 5'd31)
                        state <= DONE;
                end
                DONE: begin
                    pend_hp  <= result;
                    pend_vld <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_square_period_gen.sv
// Directed bench for square_period_gen at CLK_HZ = 50 MHz: reset, latency, retune, stop and a frequency table.
module tb_square_period_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] freq = '0;
    logic        square, busy, running;
    logic [31:0] half_period;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] f;
        logic [31:0] hp;
    } vec_t;

    vec_t vecs[8];

    square_period_gen #(.CLK_HZ(50_000_000)) dut (
        .clk(clk), .rst_n(rst_n), .freq(freq), .square(square),
        .busy(busy), .running(running), .half_period(half_period)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_running(input logic val, input int budget, input string name);
        int i = 0;
        while (running !== val && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (running !== val) check({name, "_timeout"}, 32'(running), 32'(val));
    endtask

    task automatic run_len(input logic level, input int budget, output int n);
        n = 0;
        while (square === level && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_square"}, 32'(square), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_running"}, 32'(running), 32'd0);
        check({name, "_hp"}, half_period, 32'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{32'd999_999,      32'd25};
        vecs[1] = '{32'd5_000_000,    32'd5};
        vecs[2] = '{32'd3_000_000,    32'd8};
        vecs[3] = '{32'd100_000,      32'd250};
        vecs[4] = '{32'd25_000_000,   32'd1};
        vecs[5] = '{32'd30_000_000,   32'd1};
        vecs[6] = '{32'hFFFF_FFFF,    32'd1};
        vecs[7] = '{32'd1,            32'd25_000_000};

        // power-on reset
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");

        // release with freq held: division must start on the very first edge
        freq = 32'd1000;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); check("busy_first_edge", 32'(busy), 32'd1);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_in_div");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("busy_len", n, 33);
        wait_running(1'b1, 5, "basic_load");
        check("basic_hp", half_period, 32'd25000);
        check("basic_sq_after_load", 32'(square), 32'd0);
        run_len(1'b0, 30000, n);
        check("basic_low_run", n, 25000);
        repeat (100) @(negedge clk);
        check("basic_high", 32'(square), 32'd1);
        freq = 32'd0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_in_high");
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst_running", 32'(running), 32'd0);
        check("idle_after_rst_busy", 32'(busy), 32'd0);

        // request changes at divide step 10: first result lands, then the newer one
        freq = 32'd1000;
        @(negedge clk);
        repeat (10) @(negedge clk);
        freq = 32'd5000;
        wait_running(1'b1, 40, "chg_load");
        check("chg_first_hp", half_period, 32'd25000);
        check("chg_second_div", 32'(busy), 32'd1);
        run_len(1'b0, 30000, n);
        check("chg_first_low", n, 25000);
        check("chg_final_hp", half_period, 32'd5000);

        // stop: current high half finishes, then output parks at 0
        freq = 32'd0;
        run_len(1'b1, 6000, n);
        check("stop_last_high", n, 5000);
        check("stop_square", 32'(square), 32'd0);
        check("stop_running", 32'(running), 32'd0);
        check("stop_hp", half_period, 32'd0);
        repeat (20) @(negedge clk);
        check("stop_hold_square", 32'(square), 32'd0);
        check("stop_hold_running", 32'(running), 32'd0);

        // restart, then retune mid high half
        freq = 32'd100_000;
        wait_running(1'b1, 50, "restart_load");
        check("restart_hp", half_period, 32'd250);
        run_len(1'b0, 300, n);
        check("restart_low", n, 250);
        n = 0;
        while (square === 1'b1 && n < 300) begin
            if (n == 50) freq = 32'd200_000;
            @(negedge clk);
            n++;
        end
        check("retune_high_full", n, 250);
        check("retune_hp", half_period, 32'd125);
        run_len(1'b0, 300, n);
        check("retune_low", n, 125);
        run_len(1'b1, 300, n);
        check("retune_high2", n, 125);
        freq = 32'd0;
        wait_running(1'b0, 300, "retune_stop");

        // frequency table, each entry started from the stopped state
        for (int i = 0; i < 8; i++) begin
            freq = vecs[i].f;
            wait_running(1'b1, 50, $sformatf("vec%0d_load", i));
            check($sformatf("vec%0d_hp", i), half_period, vecs[i].hp);
            if (vecs[i].hp <= 32'd300) begin
                run_len(1'b0, 400, n);
                check($sformatf("vec%0d_low", i), n, vecs[i].hp);
                run_len(1'b1, 400, n);
                check($sformatf("vec%0d_high", i), n, vecs[i].hp);
                freq = 32'd0;
                wait_running(1'b0, 2 * int'(vecs[i].hp) + 100, $sformatf("vec%0d_stop", i));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
